// File: rtl/pipe_hazard_scoreboard_pkg.sv
// Shared pipeline definitions: stage-entry record, forwarding-select encoding and
// stage index constants used by the hazard scoreboard.
package pipe_hazard_scoreboard_pkg;

    // Entries carry a fixed-width destination; narrower register addresses are zero-extended.
    localparam int unsigned MAX_RADDR_W = 8;

    localparam int unsigned FWD_RF  = 0;
    localparam int unsigned STG_EX  = 1;
    localparam int unsigned STG_MEM = 2;
    localparam int unsigned STG_WB  = 3;

    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic                   late;
        logic [MAX_RADDR_W-1:0] dst;
    } stg_entry_t;

endpackage

// File: rtl/pipe_hazard_scoreboard_fwd_select.sv
// Per-source priority match over the tracked stages: picks the youngest producer,
// returns the forwarded operand or flags a late-result hazard.
module fwd_select
    import pipe_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RADDR_W    = 4,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LATE_STAGE = 2,
    parameter int unsigned R0_ZERO    = 0,
    parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
    input  stg_entry_t [STAGES-1:0]        entries,
    input  logic       [RADDR_W-1:0]       src_addr,
    input  logic                           src_used,
    input  logic       [DATA_W-1:0]        rf_data,
    input  logic       [STAGES*DATA_W-1:0] stg_result,
    output logic       [SEL_W-1:0]         sel,
    output logic       [DATA_W-1:0]        data,
    output logic                           hazard
);

    logic              eligible;
    logic              hit;
    logic              hit_late;
    logic              hit_early;
    logic [SEL_W-1:0]  hit_stg;
    logic [DATA_W-1:0] hit_data;

    always_comb begin
        eligible  = src_used && !((R0_ZERO != 0) && (src_addr == '0));
        hit       = 1'b0;
        hit_late  = 1'b0;
        hit_early = 1'b0;
        hit_stg   = '0;
        hit_data  = '0;
        // Scan oldest to youngest so the lowest-numbered stage overwrites older matches.
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            if (eligible && entries[k].valid && entries[k].we &&
                entries[k].dst == MAX_RADDR_W'(src_addr)) begin
                hit       = 1'b1;
                hit_late  = entries[k].late;
                hit_early = (k + 1) < int'(LATE_STAGE);
                hit_stg   = SEL_W'(k + 1);
                hit_data  = stg_result[k*DATA_W +: DATA_W];
            end
        end
        hazard = hit && hit_late && hit_early;
        if (hit && !hazard) begin
            sel  = hit_stg;
            data = hit_data;
        end else begin
            sel  = SEL_W'(FWD_RF);
            data = rf_data;
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard tracker and operand-forwarding unit: shift register of in-flight destinations,
// per-source forwarding selects, load-use stall and saturating stall counter.
module pipe_hazard_scoreboard
    import pipe_hazard_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RADDR_W    = 4,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned NSRC       = 2,
    parameter int unsigned LATE_STAGE = 2,
    parameter int unsigned R0_ZERO    = 0,
    parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NSRC*RADDR_W-1:0]   id_src_addr,
    input  logic [NSRC-1:0]           id_src_used,
    input  logic [RADDR_W-1:0]        id_dst_addr,
    input  logic                      id_dst_we,
    input  logic                      id_dst_late,
    input  logic                      flush,
    input  logic                      halt,
    input  logic [NSRC*DATA_W-1:0]    rf_data,
    input  logic [STAGES*DATA_W-1:0]  stg_result,
    output logic [NSRC*SEL_W-1:0]     fwd_sel,
    output logic [NSRC*DATA_W-1:0]    fwd_data,
    output logic                      stall,
    output logic [STAGES-1:0]         stg_valid,
    output logic [15:0]               stall_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    stg_entry_t [STAGES-1:0] entries_q;
    stg_entry_t [STAGES-1:0] entries_d;
    stg_entry_t              id_entry;
    logic       [15:0]       stall_cnt_q;
    logic       [15:0]       stall_cnt_d;
    logic       [NSRC-1:0]   hazard;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        fwd_select #(
            .DATA_W     (DATA_W),
            .RADDR_W    (RADDR_W),
            .STAGES     (STAGES),
            .LATE_STAGE (LATE_STAGE),
            .R0_ZERO    (R0_ZERO),
            .SEL_W      (SEL_W)
        ) u_fwd_select (
            .entries    (entries_q),
            .src_addr   (id_src_addr[s*RADDR_W +: RADDR_W]),
            .src_used   (id_src_used[s]),
            .rf_data    (rf_data[s*DATA_W +: DATA_W]),
            .stg_result (stg_result),
            .sel        (fwd_sel[s*SEL_W +: SEL_W]),
            .data       (fwd_data[s*DATA_W +: DATA_W]),
            .hazard     (hazard[s])
        );
    end

    // Flush dominates a hazard: the squashed instruction must not hold the front end.
    assign stall = id_valid && !flush && (|hazard);

    always_comb begin
        id_entry       = '0;
        id_entry.valid = id_valid && !stall && !flush;
        id_entry.we    = id_dst_we;
        id_entry.late  = id_dst_late;
        id_entry.dst   = MAX_RADDR_W'(id_dst_addr);

        entries_d   = entries_q;
        stall_cnt_d = stall_cnt_q;
        if (!halt) begin
            entries_d[STG_EX-1] = id_entry;
            for (int k = 1; k < int'(STAGES); k++) begin
                entries_d[k] = entries_q[k-1];
            end
            if (stall && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            entries_q   <= entries_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stg_valid = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            stg_valid[k] = entries_q[k].valid;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard (R0_ZERO=1, other parameters default).
module tb_pipe_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [7:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [3:0]  id_dst_addr;
    logic        id_dst_we;
    logic        id_dst_late;
    logic        flush;
    logic        halt;
    logic [31:0] rf_data;
    logic [47:0] stg_result;
    logic [3:0]  fwd_sel;
    logic [31:0] fwd_data;
    logic        stall;
    logic [2:0]  stg_valid;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard #(
        .DATA_W     (16),
        .RADDR_W    (4),
        .STAGES     (3),
        .NSRC       (2),
        .LATE_STAGE (2),
        .R0_ZERO    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .id_dst_addr (id_dst_addr),
        .id_dst_we   (id_dst_we),
        .id_dst_late (id_dst_late),
        .flush       (flush),
        .halt        (halt),
        .rf_data     (rf_data),
        .stg_result  (stg_result),
        .fwd_sel     (fwd_sel),
        .fwd_data    (fwd_data),
        .stall       (stall),
        .stg_valid   (stg_valid),
        .stall_cnt   (stall_cnt)
    );

    task automatic idle();
        id_valid    = 1'b0;
        id_src_addr = '0;
        id_src_used = '0;
        id_dst_addr = '0;
        id_dst_we   = 1'b0;
        id_dst_late = 1'b0;
        flush       = 1'b0;
        halt        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] dst, input logic late);
        idle();
        id_valid    = 1'b1;
        id_dst_addr = dst;
        id_dst_we   = 1'b1;
        id_dst_late = late;
        step();
        idle();
        #1;
    endtask

    // ID instruction reading src1:src0, writing nothing.
    task automatic read(input logic [3:0] s0, input logic [3:0] s1);
        idle();
        id_valid    = 1'b1;
        id_src_addr = {s1, s0};
        id_src_used = 2'b11;
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) step();
        rst = 1'b0;
        #1;
        total++; if (stg_valid !== 3'b000) begin bad++; $display("FAIL reset.stg_valid got=%b want=000", stg_valid); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset.stall_cnt got=%0d want=0", stall_cnt); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset.stall got=%b want=0", stall); end
        total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL reset.fwd_sel got=%b want=0000", fwd_sel); end
        total++; if (fwd_data !== 32'hBEEF_CAFE) begin bad++; $display("FAIL reset.fwd_data got=%h want=beefcafe", fwd_data); end
    endtask

    task automatic test_alu_chain();
        stg_result = {16'h3333, 16'h2222, 16'h1234};
        push(4'd3, 1'b0);
        read(4'd3, 4'd7);
        total++; if (stg_valid !== 3'b001) begin bad++; $display("FAIL alu.stg_valid got=%b want=001", stg_valid); end
        total++; if (fwd_sel !== 4'b0001) begin bad++; $display("FAIL alu.fwd_sel got=%b want=0001", fwd_sel); end
        total++; if (fwd_data !== 32'hBEEF_1234) begin bad++; $display("FAIL alu.fwd_data got=%h want=beef1234", fwd_data); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu.stall got=%b want=0", stall); end
        drain();
        total++; if (stg_valid !== 3'b000) begin bad++; $display("FAIL alu.drain got=%b want=000", stg_valid); end
    endtask

    task automatic test_load_use();
        stg_result = {16'h3333, 16'h2222, 16'h1234};
        push(4'd5, 1'b1);
        read(4'd5, 4'd9);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu.stall got=%b want=1", stall); end
        total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL lu.fwd_sel got=%b want=0000", fwd_sel); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL lu.cnt0 got=%0d want=0", stall_cnt); end
        step();
        total++; if (stg_valid !== 3'b010) begin bad++; $display("FAIL lu.bubble got=%b want=010", stg_valid); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu.stall2 got=%b want=0", stall); end
        total++; if (fwd_sel !== 4'b0010) begin bad++; $display("FAIL lu.fwd_sel2 got=%b want=0010", fwd_sel); end
        total++; if (fwd_data !== 32'hBEEF_2222) begin bad++; $display("FAIL lu.fwd_data2 got=%h want=beef2222", fwd_data); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu.cnt1 got=%0d want=1", stall_cnt); end
        drain();
    endtask

    task automatic test_double_producer();
        stg_result = {16'h5555, 16'h7777, 16'hAAAA};
        push(4'd2, 1'b0);
        push(4'd9, 1'b0);
        push(4'd2, 1'b0);
        read(4'd2, 4'd9);
        total++; if (fwd_sel !== 4'b1001) begin bad++; $display("FAIL dbl.fwd_sel got=%b want=1001", fwd_sel); end
        total++; if (fwd_data !== 32'h7777_AAAA) begin bad++; $display("FAIL dbl.fwd_data got=%h want=7777aaaa", fwd_data); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL dbl.stall got=%b want=0", stall); end
        idle();
        step();
        read(4'd2, 4'd9);
        total++; if (fwd_sel !== 4'b1110) begin bad++; $display("FAIL dbl.shift1 got=%b want=1110", fwd_sel); end
        idle();
        step();
        read(4'd2, 4'd9);
        total++; if (fwd_sel !== 4'b0011) begin bad++; $display("FAIL dbl.wb got=%b want=0011", fwd_sel); end
        total++; if (fwd_data !== 32'hBEEF_5555) begin bad++; $display("FAIL dbl.wb_data got=%h want=beef5555", fwd_data); end
        drain();
    endtask

    task automatic test_flush_hazard();
        push(4'd5, 1'b1);
        read(4'd5, 4'd9);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush.stall got=%b want=0", stall); end
        step();
        total++; if (stg_valid !== 3'b010) begin bad++; $display("FAIL flush.stg_valid got=%b want=010", stg_valid); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL flush.cnt got=%0d want=1", stall_cnt); end
        drain();
    endtask

    task automatic test_halt();
        stg_result = {16'h3333, 16'h2222, 16'h1234};
        push(4'd6, 1'b1);
        read(4'd9, 4'd6);
        halt = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (stg_valid !== 3'b001) begin bad++; $display("FAIL halt.stg_valid[%0d] got=%b want=001", i, stg_valid); end
            total++; if (stall !== 1'b1) begin bad++; $display("FAIL halt.stall[%0d] got=%b want=1", i, stall); end
            total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL halt.cnt[%0d] got=%0d want=1", i, stall_cnt); end
        end
        halt = 1'b0;
        step();
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL halt.rel_cnt got=%0d want=2", stall_cnt); end
        total++; if (stg_valid !== 3'b010) begin bad++; $display("FAIL halt.rel_valid got=%b want=010", stg_valid); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL halt.rel_stall got=%b want=0", stall); end
        total++; if (fwd_sel !== 4'b1000) begin bad++; $display("FAIL halt.rel_sel got=%b want=1000", fwd_sel); end
        total++; if (fwd_data !== 32'h2222_CAFE) begin bad++; $display("FAIL halt.rel_data got=%h want=2222cafe", fwd_data); end
        drain();
    endtask

    task automatic test_r0_and_reset();
        push(4'd0, 1'b1);
        read(4'd0, 4'd0);
        total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL r0.fwd_sel got=%b want=0000", fwd_sel); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0.stall got=%b want=0", stall); end
        total++; if (fwd_data !== 32'hBEEF_CAFE) begin bad++; $display("FAIL r0.fwd_data got=%h want=beefcafe", fwd_data); end
        push(4'd4, 1'b1);
        read(4'd4, 4'd0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rst.pre_stall got=%b want=1", stall); end
        rst  = 1'b1;
        halt = 1'b1;
        step();
        rst  = 1'b0;
        #1;
        total++; if (stg_valid !== 3'b000) begin bad++; $display("FAIL rst.stg_valid got=%b want=000", stg_valid); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst.cnt got=%0d want=0", stall_cnt); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst.stall got=%b want=0", stall); end
        total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL rst.fwd_sel got=%b want=0000", fwd_sel); end
        total++; if (fwd_data !== 32'hBEEF_CAFE) begin bad++; $display("FAIL rst.fwd_data got=%h want=beefcafe", fwd_data); end
        idle();
    endtask

    initial begin
        rst        = 1'b1;
        rf_data    = {16'hBEEF, 16'hCAFE};
        stg_result = {16'h3333, 16'h2222, 16'h1234};
        idle();
        test_reset();
        test_alu_chain();
        test_load_use();
        test_double_producer();
        test_flush_hazard();
        test_halt();
        test_r0_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
